// File: rtl/shift_reg_universal.sv
// ---------------------------------------------------------------------------
// shift_reg_universal
//   Universal shift register with manual operations (hold, shift right,
//   shift left, parallel load) and an automatic burst engine that performs
//   a programmed number of shifts in one direction and pulses done.
//
//   Optional feature macro: SHIFT_REG_ROTATE_EN
//     When defined, adds input 'rotate'. With rotate=1 the bit entering on a
//     shift is the bit leaving that same cycle (rotation), for both manual and
//     burst shifts. When undefined the entering bit is always serial_in.
//
//   Parameters
//     NBITS       register width (>= 2)
//     RESET_VALUE value loaded into q on reset
//
//   Ports
//     clk_2       clock, all state updates on rising edge
//     reset_n     asynchronous active-low reset
//     mode        manual op: 00 hold, 01 right, 10 left, 11 load
//     serial_in   bit entering on shift
//     d           parallel load data
//     start       launches automatic burst (only honoured in IDLE)
//     dir         burst direction: 0 right, 1 left
//     shift_cnt   number of burst shifts (values above NBITS honoured)
//     rotate      (SHIFT_REG_ROTATE_EN only) rotate instead of serial_in
//     q           register contents
//     serial_out  last bit shifted out
//     busy        high in SHIFT and DONE
//     done        one-cycle burst completion pulse
// ---------------------------------------------------------------------------
module shift_reg_universal #(
  parameter int                 NBITS       = 4,
  parameter logic [NBITS-1:0]   RESET_VALUE = '0,
  localparam int                CNTW        = $clog2(NBITS + 1)
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  input  logic [NBITS-1:0] d,
  input  logic             start,
  input  logic             dir,
  input  logic [CNTW-1:0]  shift_cnt,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [NBITS-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNTW-1:0]  rem_q,   rem_d;
  logic             dir_q,   dir_d;
  logic [NBITS-1:0] q_q,     q_d;
  logic             so_q,    so_d;

  // One shift step. Returns {bit_shifted_out, new_register_value}.
  function automatic logic [NBITS:0] shift_step(
    input logic [NBITS-1:0] cur,
    input logic             left,
    input logic             in_bit
  );
    if (left) begin
      shift_step = {cur[NBITS-1], cur[NBITS-2:0], in_bit};
    end else begin
      shift_step = {cur[0], in_bit, cur[NBITS-1:1]};
    end
  endfunction

  // Bit entering the register; with rotation it is the bit leaving.
  function automatic logic entry_bit(
    input logic [NBITS-1:0] cur,
    input logic             left,
    input logic             rot,
    input logic             sin
  );
    if (rot) begin
      entry_bit = left ? cur[NBITS-1] : cur[0];
    end else begin
      entry_bit = sin;
    end
  endfunction

  logic rot_en;
`ifdef SHIFT_REG_ROTATE_EN
  assign rot_en = rotate;
`else
  assign rot_en = 1'b0;
`endif

  logic [NBITS:0] step_res;
  logic           step_left;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    q_d       = q_q;
    so_d      = so_q;
    step_left = 1'b0;
    step_res  = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Start outranks mode; the register holds on the launch edge.
          dir_d = dir;
          rem_d = shift_cnt;
          state_d = (shift_cnt == '0) ? DONE : SHIFT;
        end else begin
          step_left = mode[1];
          step_res  = shift_step(q_q, step_left,
                                 entry_bit(q_q, step_left, rot_en, serial_in));
          unique case (mode)
            2'b01, 2'b10: begin
              q_d  = step_res[NBITS-1:0];
              so_d = step_res[NBITS];
            end
            2'b11:   q_d = d;
            default: ;
          endcase
        end
      end
      SHIFT: begin
        step_left = dir_q;
        step_res  = shift_step(q_q, step_left,
                               entry_bit(q_q, step_left, rot_en, serial_in));
        q_d   = step_res[NBITS-1:0];
        so_d  = step_res[NBITS];
        rem_d = rem_q - CNTW'(1);
        if (rem_q == CNTW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        rem_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      q_q     <= RESET_VALUE;
      so_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      q_q     <= q_d;
      so_q    <= so_d;
    end
  end

  assign q          = q_q;
  assign serial_out = so_q;
  assign busy       = (state_q == SHIFT) || (state_q == DONE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_shift_reg_universal.sv
module tb_shift_reg_universal;

  localparam int NBITS = 4;
  localparam int CNTW  = $clog2(NBITS + 1);

  logic             clk_2 = 1'b0;
  logic             reset_n;
  logic [1:0]       mode;
  logic             serial_in;
  logic [NBITS-1:0] d;
  logic             start;
  logic             dir;
  logic [CNTW-1:0]  shift_cnt;
`ifdef SHIFT_REG_ROTATE_EN
  logic             rotate;
`endif
  logic [NBITS-1:0] q;
  logic             serial_out;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;

  shift_reg_universal #(.NBITS(NBITS), .RESET_VALUE('0)) dut (
    .clk_2      (clk_2),
    .reset_n    (reset_n),
    .mode       (mode),
    .serial_in  (serial_in),
    .d          (d),
    .start      (start),
    .dir        (dir),
    .shift_cnt  (shift_cnt),
`ifdef SHIFT_REG_ROTATE_EN
    .rotate     (rotate),
`endif
    .q          (q),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    mode      = 2'b00;
    serial_in = 1'b0;
    d         = '0;
    start     = 1'b0;
    dir       = 1'b0;
    shift_cnt = '0;
`ifdef SHIFT_REG_ROTATE_EN
    rotate    = 1'b0;
`endif
    #12;
    chk("rst_q",    q, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_so",   serial_out, 1'b0);
    reset_n = 1'b1;

    // Manual shift right with serial_in=1
    mode = 2'b01; serial_in = 1'b1;
    tick(); chk("sr1", q, 4'b1000);
    tick(); chk("sr2", q, 4'b1100);
    tick(); chk("sr3", q, 4'b1110);
    tick(); chk("sr4", q, 4'b1111);
    chk("sr_so", serial_out, 1'b0);
    mode = 2'b11; d = 4'b1010;
    tick(); chk("load", q, 4'b1010);
    chk("load_so", serial_out, 1'b0);
    mode = 2'b10; serial_in = 1'b1;
    tick(); chk("sl", q, 4'b0101);
    chk("sl_so", serial_out, 1'b1);
    mode = 2'b00;
    tick(); chk("hold", q, 4'b0101);
    chk("hold_so", serial_out, 1'b1);

    // Burst left, 3 shifts from 1011; mode=load must be overridden by start
    mode = 2'b11; d = 4'b1011;
    tick();
    d = 4'b0000;
    start = 1'b1; dir = 1'b1; shift_cnt = 3'd3; serial_in = 1'b0;
    tick(); chk("b_k_q", q, 4'b1011); chk("b_k_busy", busy, 1'b1);
    chk("b_k_done", done, 1'b0);
    start = 1'b0; mode = 2'b00;
    tick(); chk("b1", q, 4'b0110); chk("b1_done", done, 1'b0);
    tick(); chk("b2", q, 4'b1100);
    tick(); chk("b3", q, 4'b1000); chk("b3_done", done, 1'b1);
    chk("b3_busy", busy, 1'b1); chk("b3_so", serial_out, 1'b1);
    tick(); chk("b_idle_done", done, 1'b0); chk("b_idle_busy", busy, 1'b0);
    chk("b_idle_q", q, 4'b1000);

    // Zero-length burst
    start = 1'b1; shift_cnt = 3'd0;
    tick(); chk("z_done", done, 1'b1); chk("z_q", q, 4'b1000);
    chk("z_busy", busy, 1'b1);
    start = 1'b0;
    tick(); chk("z_after", done, 1'b0); chk("z_after_busy", busy, 1'b0);

    // Burst right 2 shifts; start/dir/cnt changes during SHIFT are ignored
    start = 1'b1; dir = 1'b0; shift_cnt = 3'd2; serial_in = 1'b1;
    tick();
    start = 1'b1; dir = 1'b1; shift_cnt = 3'd7;
    tick(); chk("ig1", q, 4'b1100); chk("ig1_done", done, 1'b0);
    start = 1'b0;
    tick(); chk("ig2", q, 4'b1110); chk("ig2_done", done, 1'b1);
    tick(); chk("ig_idle", busy, 1'b0);

    // Count above NBITS honoured: 5 right shifts with serial_in=0
    start = 1'b1; dir = 1'b0; shift_cnt = 3'd5; serial_in = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("big4_q", q, 4'b0000); chk("big4_done", done, 1'b0);
    chk("big4_busy", busy, 1'b1);
    tick(); chk("big5_done", done, 1'b1); chk("big5_so", serial_out, 1'b0);
    tick();

    // Reset in the middle of a burst
    mode = 2'b11; d = 4'b1111;
    tick();
    mode = 2'b00;
    start = 1'b1; dir = 1'b1; shift_cnt = 3'd3; serial_in = 1'b0;
    tick();
    start = 1'b0;
    tick(); chk("mr1", q, 4'b1110);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_q", q, 4'b0000); chk("mr_busy", busy, 1'b0);
    chk("mr_done", done, 1'b0); chk("mr_so", serial_out, 1'b0);
    #2 reset_n = 1'b1;
    tick(); chk("mr_post_done", done, 1'b0); chk("mr_post_busy", busy, 1'b0);
    tick(); chk("mr_post2_done", done, 1'b0); chk("mr_post_q", q, 4'b0000);

`ifdef SHIFT_REG_ROTATE_EN
    mode = 2'b11; d = 4'b0001;
    tick();
    mode = 2'b01; rotate = 1'b1; serial_in = 1'b0;
    tick(); chk("rot1", q, 4'b1000); chk("rot1_so", serial_out, 1'b1);
    tick(); chk("rot2", q, 4'b0100);
    tick(); tick(); tick(); chk("rot5", q, 4'b1000);
    rotate = 1'b0; mode = 2'b00;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
